// File: rtl/phase_dev_meter.sv
// phase_dev_meter: unwraps wrapped PM phase, tracks per-window max/min, averages over 2^AVG_LOG2 windows.
// Latency: results and dev_valid appear 4 cycles after the in_valid cycle of the final sample.
// Backpressure: none; every in_valid sample taken in PRIME/RUN/DONE is processed, there is no ready.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   trigger             one-cycle pulse, clears measurement state and (re)starts in PRIME
//   continuous          1 = restart automatically after each result (sampled in DONE)
//   in_valid, phase_in  wrapped signed phase sample and its qualifier
//   phase_max/min/dev   averaged window max, min and their difference (held until next result)
//   dev_valid           one-cycle pulse when the three results update
//   busy                high while a measurement is in progress (PRIME/RUN/DONE)
//   offset_ovf          sticky: the unwrap offset hit the DEV_W range limit
module phase_dev_meter #(
  parameter int PHASE_W  = 32,
  parameter int DEV_W    = 42,
  parameter int CNT_W    = 32,
  parameter int WIN_LEN  = 3600,
  parameter int AVG_LOG2 = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trigger,
  input  logic                      continuous,
  input  logic                      in_valid,
  input  logic signed [PHASE_W-1:0] phase_in,
  output logic signed [DEV_W-1:0]   phase_max,
  output logic signed [DEV_W-1:0]   phase_min,
  output logic signed [DEV_W-1:0]   phase_dev,
  output logic                      dev_valid,
  output logic                      busy,
  output logic                      offset_ovf
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam int ACC_W = DEV_W + AVG_LOG2;
  localparam logic [8:0]       LAST_WIN = 9'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WIN_LEN - 1);

  // Unwrap arithmetic runs one bit wider than DEV_W so the saturation test can see the overflow.
  localparam logic signed [DEV_W:0] STEP  = {{(DEV_W-PHASE_W){1'b0}}, 1'b1, {PHASE_W{1'b0}}};
  localparam logic signed [DEV_W:0] HALF  = {{(DEV_W-PHASE_W+1){1'b0}}, 1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic signed [DEV_W:0] NHALF = -HALF;
  localparam logic signed [DEV_W:0] DMAX  = {2'b00, {(DEV_W-1){1'b1}}};
  localparam logic signed [DEV_W:0] DMIN  = {2'b11, {(DEV_W-1){1'b0}}};

  state_t state_q, state_d;

  // front end: unwrap
  logic signed [DEV_W-1:0] prev_q, offset_q, offset_d, s1_x_q, u_q, x_dw;
  logic signed [DEV_W:0]   x_e, prev_e, off_e, diff, off_try;
  logic                    s1_vld_q, u_vld_q, off_sat, accept;

  // window / accumulation
  logic signed [DEV_W-1:0] wmax_q, wmax_d, wmin_q, wmin_d;
  logic signed [ACC_W-1:0] acc_max_q, acc_max_d, acc_min_q, acc_min_d;
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic [8:0]              nwin_q, nwin_d;
  logic                    win_en, last_win;
  logic signed [DEV_W-1:0] avg_max, avg_min;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (trigger) begin
      state_d = PRIME;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        PRIME:   if (in_valid) state_d = RUN;
        RUN:     if (last_win) state_d = DONE;
        DONE:    state_d = continuous ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // ---------------- unwrap ----------------
  assign accept = in_valid && !trigger && (state_q != IDLE);
  assign x_dw   = DEV_W'(phase_in);
  assign x_e    = (DEV_W+1)'(phase_in);
  assign prev_e = {prev_q[DEV_W-1], prev_q};
  assign off_e  = {offset_q[DEV_W-1], offset_q};
  assign diff   = x_e - prev_e;

  always_comb begin
    off_try = off_e;
    if (diff >= HALF)       off_try = off_e - STEP;
    else if (diff < NHALF)  off_try = off_e + STEP;
    off_sat  = (off_try > DMAX) || (off_try < DMIN);
    offset_d = off_sat ? offset_q : off_try[DEV_W-1:0];
  end

  // Stage 1 registers the sample with its updated offset; stage 2 forms u.
  // offset_q seen at stage 2 is exactly the offset produced by that sample,
  // because a following sample only changes it on the same edge u is captured.
  always_ff @(posedge clk) begin
    if (rst || trigger) begin
      prev_q     <= '0;
      offset_q   <= '0;
      s1_x_q     <= '0;
      s1_vld_q   <= 1'b0;
      u_q        <= '0;
      u_vld_q    <= 1'b0;
      offset_ovf <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      u_vld_q  <= s1_vld_q;
      u_q      <= s1_x_q + offset_q;
      if (accept) begin
        prev_q <= x_dw;
        s1_x_q <= x_dw;
        if (state_q == PRIME) begin
          offset_q <= '0;
        end else begin
          offset_q <= offset_d;
          if (off_sat) offset_ovf <= 1'b1;
        end
      end
    end
  end

  // ---------------- windows ----------------
  // A u landing in DONE belongs to the next measurement, so only keep it when restarting.
  assign win_en = u_vld_q && ((state_q == RUN) || (state_q == DONE && continuous));

  always_comb begin
    wmax_d    = wmax_q;
    wmin_d    = wmin_q;
    wcnt_d    = wcnt_q;
    nwin_d    = nwin_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    last_win  = 1'b0;
    if (state_q == DONE) begin
      acc_max_d = '0;
      acc_min_d = '0;
      wcnt_d    = '0;
      nwin_d    = '0;
    end
    if (win_en) begin
      if (wcnt_d == '0) begin
        wmax_d = u_q;
        wmin_d = u_q;
      end else begin
        if (u_q > wmax_d) wmax_d = u_q;
        if (u_q < wmin_d) wmin_d = u_q;
      end
      if (wcnt_d == LAST_SMP) begin
        acc_max_d = acc_max_d + ACC_W'(wmax_d);
        acc_min_d = acc_min_d + ACC_W'(wmin_d);
        wcnt_d    = '0;
        if (nwin_d == LAST_WIN) begin
          last_win = 1'b1;
          nwin_d   = '0;
        end else begin
          nwin_d = nwin_d + 9'd1;
        end
      end else begin
        wcnt_d = wcnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || trigger) begin
      wmax_q    <= '0;
      wmin_q    <= '0;
      wcnt_q    <= '0;
      nwin_q    <= '0;
      acc_max_q <= '0;
      acc_min_q <= '0;
    end else begin
      wmax_q    <= wmax_d;
      wmin_q    <= wmin_d;
      wcnt_q    <= wcnt_d;
      nwin_q    <= nwin_d;
      acc_max_q <= acc_max_d;
      acc_min_q <= acc_min_d;
    end
  end

  // ---------------- results ----------------
  // Arithmetic shift floors toward -inf.
  assign avg_max = DEV_W'(acc_max_q >>> AVG_LOG2);
  assign avg_min = DEV_W'(acc_min_q >>> AVG_LOG2);

  // Results hold across trigger; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_max <= '0;
      phase_min <= '0;
      phase_dev <= '0;
      dev_valid <= 1'b0;
    end else begin
      dev_valid <= 1'b0;
      if (state_q == DONE && !trigger) begin
        phase_max <= avg_max;
        phase_min <= avg_min;
        phase_dev <= avg_max - avg_min;
        dev_valid <= 1'b1;
      end
    end
  end

endmodule
